ps2_receiver: RTL and testbench

Deserializes the raw PS/2 keyboard line pair (clock and data from the connector) into scan-code bytes and announces each byte with a one-cycle strobe. It sits directly upstream of the port controller and drives that controller's received-data byte and received-data strobe inputs. These are the signals the simulation top currently fakes with a hand-written 8'h76 byte and strobe. It runs in the port controller's clock domain (clk50) and outputs raw bytes only; make/break/extended decoding (F0, E0) is left to software behind the port.

---
 rtl/ps2_receiver.sv | 141 ++++++++++++++
 tb/tb_ps2_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard line deserializer producing scan-code bytes with strobes
// Synchronizes and glitch-filters the raw lines, then frames start/8 data/odd parity/stop bits.
module ps2_receiver #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_data_clk,
  output logic       ps2_err,
  output logic       ps2_busy
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, dat_f, clk_f_q;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic          sample, clk_edge;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // A filtered level flips only after FILTER consecutive disagreeing samples.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
    end else if (clk_s2 == clk_f) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FW'(FILTER - 1)) begin
      clk_f   <= clk_s2;
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      dat_f   <= 1'b1;
      dat_cnt <= '0;
    end else if (dat_s2 == dat_f) begin
      dat_cnt <= '0;
    end else if (dat_cnt == FW'(FILTER - 1)) begin
      dat_f   <= dat_s2;
      dat_cnt <= '0;
    end else begin
      dat_cnt <= dat_cnt + 1'b1;
    end
  end

  assign sample   = clk_f_q & ~clk_f;
  assign clk_edge = clk_f_q ^ clk_f;
  assign ps2_busy = (state != IDLE);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      clk_f_q      <= 1'b1;
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      tcnt         <= '0;
      ps2_data     <= '0;
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
    end else begin
      clk_f_q      <= clk_f;
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;

      if (clk_edge || state == IDLE)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + 1'b1;

      if (sample) begin
        case (state)
          IDLE: begin
            if (!dat_f) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              ps2_err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= dat_f;
            state <= STOP;
          end
          default: begin
            if (dat_f && ((^shreg) ^ par)) begin
              ps2_data     <= shreg;
              ps2_data_clk <= 1'b1;
            end else begin
              ps2_err <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (!clk_edge && state != IDLE && tcnt == TW'(TIMEOUT)) begin
        // An edge in this cycle restarts the window, so only a quiet line times out.
        state   <= IDLE;
        ps2_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - directed-frame bench for ps2_receiver with an event-queue model
module tb_ps2_receiver;

  logic       clk50 = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_data_clk, ps2_err, ps2_busy;

  ps2_receiver #(.FILTER(8), .TIMEOUT(1000)) dut (
    .clk50(clk50), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ps2_data(ps2_data), .ps2_data_clk(ps2_data_clk), .ps2_err(ps2_err), .ps2_busy(ps2_busy)
  );

  always #5 clk50 = ~clk50;

  typedef struct packed {
    logic       is_err;
    logic [7:0] b;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_vec = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_rise = 0;
  int         err_cyc = 0;

  always @(posedge clk50) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Model: a frame is good iff stop is 1 and data plus parity hold an odd number of ones.
  task automatic expect_frame(input logic [7:0] b, input logic par, input logic stop);
    ev_t e;
    e.is_err = !(stop && (((^b) ^ par) == 1'b1));
    e.b      = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    ev_t e;
    e.is_err = 1'b1;
    e.b      = 8'h00;
    exp_q.push_back(e);
  endtask

  always @(negedge clk50) begin
    if (!rst) begin
      ev_t e;
      if (ps2_data_clk && ps2_err)
        chk("strobe_overlap", 1, 0);
      if (ps2_data_clk) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_data_strobe", {24'h0, ps2_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind_data", {31'h0, e.is_err}, 0);
          chk("strobe_byte", {24'h0, ps2_data}, {24'h0, e.b});
          if (!e.is_err) model_data = e.b;
        end
      end
      if (ps2_err) begin
        err_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_err_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind_err", {31'h0, e.is_err}, 1);
        end
      end
      chk("held_data", {24'h0, ps2_data}, {24'h0, model_data});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop,
                           input int nbits, input bit busy_chk, input bit dat_glitch);
    logic [10:0] fr;
    fr = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (dat_glitch && i == 5) begin
        ps2_dat = fr[i];
        cycles(3);
        ps2_dat = ~fr[i];
        cycles(3);
        ps2_dat = fr[i];
        cycles(4);
      end else begin
        ps2_dat = fr[i];
        cycles(10);
      end
      ps2_clk = 1'b0;
      cycles(10);
      if (busy_chk && i == 4) chk("busy_mid_frame", {31'h0, ps2_busy}, 1);
      cycles(10);
      ps2_clk = 1'b1;
      last_rise = cyc;
      cycles(10);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycles(1);
    cycles(3);
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    repeat (50000) @(posedge clk50);
    $display("FAIL watchdog: run still going after 50000 cycles, required to finish");
    $fatal(1);
  end

  initial begin
    cycles(5);
    chk("reset_data", {24'h0, ps2_data}, 0);
    chk("reset_data_clk", {31'h0, ps2_data_clk}, 0);
    chk("reset_err", {31'h0, ps2_err}, 0);
    chk("reset_busy", {31'h0, ps2_busy}, 0);
    rst = 1'b0;
    cycles(30);

    expect_frame(8'h76, 1'b0, 1'b1);
    send_bits(8'h76, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    drain("drain_76", 100);
    chk("data_76", {24'h0, ps2_data}, 32'h76);
    chk("idle_busy_76", {31'h0, ps2_busy}, 0);

    expect_frame(8'h2E, 1'b1, 1'b1);
    expect_frame(8'hF0, 1'b1, 1'b1);
    send_bits(8'h2E, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    send_bits(8'hF0, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    drain("drain_2e_f0", 100);
    chk("data_f0", {24'h0, ps2_data}, 32'hF0);

    expect_frame(8'h76, 1'b1, 1'b1);
    send_bits(8'h76, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    drain("drain_bad_parity", 100);
    chk("keep_after_parity_err", {24'h0, ps2_data}, 32'hF0);
    expect_frame(8'h76, 1'b0, 1'b0);
    send_bits(8'h76, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    drain("drain_bad_stop", 100);
    chk("keep_after_stop_err", {24'h0, ps2_data}, 32'hF0);

    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(60);
    chk("clk_glitch_busy", {31'h0, ps2_busy}, 0);
    expect_frame(8'h1C, 1'b0, 1'b1);
    send_bits(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b1);
    drain("drain_1c", 100);
    chk("data_1c", {24'h0, ps2_data}, 32'h1C);

    expect_err();
    send_bits(8'h5A, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    drain("drain_timeout", 1200);
    n_vec++;
    if (!((err_cyc - last_rise) >= 1000 && (err_cyc - last_rise) <= 1020)) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, required 1000..1020", err_cyc - last_rise);
    end
    chk("timeout_busy", {31'h0, ps2_busy}, 0);
    chk("keep_after_timeout", {24'h0, ps2_data}, 32'h1C);
    expect_frame(8'h5A, 1'b1, 1'b1);
    send_bits(8'h5A, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    drain("drain_5a", 100);
    chk("data_5a", {24'h0, ps2_data}, 32'h5A);

    send_bits(8'h29, 1'b0, 1'b1, 6, 1'b1, 1'b0);
    cycles(3);
    rst = 1'b1;
    #1;
    chk("midrst_data", {24'h0, ps2_data}, 0);
    chk("midrst_data_clk", {31'h0, ps2_data_clk}, 0);
    chk("midrst_err", {31'h0, ps2_err}, 0);
    chk("midrst_busy", {31'h0, ps2_busy}, 0);
    model_data = 8'h00;
    cycles(5);
    rst = 1'b0;
    cycles(50);
    expect_frame(8'h29, 1'b0, 1'b1);
    send_bits(8'h29, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    drain("drain_29", 100);
    chk("data_29", {24'h0, ps2_data}, 32'h29);

    cycles(50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
